// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Counter wide enough to hold 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order prefetch FIFO of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy; flush wins over everything
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch front end (optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSel,
    input  logic [XLEN-1:0] alu_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic [XLEN-1:0] I,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic            misalign_err
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            misalign_q, misalign_d;

    logic            halted, halted_nxt;
    logic            req_fire, req_hold, redirect;
    logic [XLEN-1:0] target_aligned, base_pc;
    logic [CW-1:0]   count_nxt;
    logic [CW:0]     credit_sum;
    logic            credit_ok;

    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign halted     = misalign_q;
    assign halted_nxt = misalign_d;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^alu_target[1:0];
    assign halted          = 1'b0;
    assign halted_nxt      = 1'b0;
`endif

    assign req_fire       = req_valid_q && imem_req_ready;
    assign req_hold       = req_valid_q && !imem_req_ready;
    assign inst_valid     = !fifo_empty && !halted;
    assign fifo_pop       = inst_valid && inst_ready;
    assign redirect       = fifo_pop && PCSel;
    assign target_aligned = {alu_target[XLEN-1:2], 2'b00};
    // A response in the redirect cycle, a discard credit, or a halt all drop the word
    assign fifo_push      = imem_resp_valid && (discard_q == '0) && !redirect && !halted;
    assign push_entry     = '{pc: resp_pc_q, instr: imem_resp_data};

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign I              = inst_valid ? fifo_head.instr : NOP_INSTR;
    assign inst_pc        = inst_valid ? fifo_head.pc : resp_pc_q;
    assign misalign_err   = misalign_q;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Credits, discard count, PC tracking and request issue
    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        discard_d = discard_q;
        if (imem_resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (redirect) begin
            // Everything still in flight plus a stalled request belongs to the old stream
            discard_d = outstanding_d + CW'(req_hold);
        end

        resp_pc_d = resp_pc_q;
        if (redirect) begin
            resp_pc_d = target_aligned;
        end else if (fifo_push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q || (redirect && (alu_target[1:0] != 2'b00));
`else
        misalign_d = 1'b0;
`endif

        count_nxt  = redirect ? '0 : (fifo_count + CW'(fifo_push) - CW'(fifo_pop));
        credit_sum = {1'b0, outstanding_d} + {1'b0, count_nxt};
        credit_ok  = credit_sum < (CW + 1)'(FIFO_DEPTH);
        base_pc    = redirect ? target_aligned : fetch_pc_q;

        // A raised request keeps its address until accepted, even across a redirect
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        fetch_pc_d  = base_pc;
        if (req_hold) begin
            req_valid_d = 1'b1;
        end else if (!halted_nxt && credit_ok) begin
            req_valid_d = 1'b1;
            req_addr_d  = base_pc;
            fetch_pc_d  = base_pc + 32'd4;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            resp_pc_q     <= resp_pc_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misalign_q    <= misalign_d;
        end
    end

    // Credit accounting guarantees the prefetch FIFO always has room for a kept response
    a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
